nr_symbol_framer: RTL and testbench

Downstream framing stage for the 5G NR IFFT/CP transmit chain. It consumes the time-domain sample stream leaving cyclic-prefix insertion and marks symbol and slot boundaries with start-of-packet, end-of-packet and symbol-index sidebands. It enforces the NR slot length, where symbols 0 and 7 carry the long CP and symbols 1–6 and 8–13 the normal CP, and flags truncated symbols. Its output feeds the DAC/radio interface packetiser.

---
 rtl/nr_symbol_framer.sv | 91 +++++++++
 tb/tb_nr_symbol_framer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nr_symbol_framer.sv
// nr_symbol_framer: marks NR symbol/slot boundaries on the post-CP sample stream and flags truncated symbols.
// Optional saturating error counter port err_cnt is built only with NR_FRAMER_ERR_CNT_EN.
module nr_symbol_framer #(
  parameter int WIDTH     = 26,
  parameter int IFFT_SIZE = 2048,
  parameter int NCP1      = 160,
  parameter int NCP2      = 144,
  parameter int N_SYMB    = 14,
  parameter int GAP_MAX   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [3:0]              out_symb,
  output logic                    out_slot_end,
`ifdef NR_FRAMER_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  output logic                    err_len
);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [11:0] LEN_LONG = 12'(IFFT_SIZE + NCP1 - 1);
  localparam logic [11:0] LEN_NORM = 12'(IFFT_SIZE + NCP2 - 1);
  localparam logic [3:0] SYMB_MID = 4'(N_SYMB / 2);
  localparam logic [3:0] SYMB_LAST = 4'(N_SYMB - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0] symb_q, symb_d;
  logic [GW-1:0] gap_q, gap_d;
  logic last_d, sop_d, eop_d, trunc_d;
  // Symbols 0 and N_SYMB/2 carry the long CP; eop is the sample at index L-1.
  always_comb begin
    last_d = cnt_q == ((symb_q == 4'd0 || symb_q == SYMB_MID) ? LEN_LONG : LEN_NORM);
    sop_d = in_valid && state_q == IDLE;
    eop_d = in_valid && state_q == ACTIVE && last_d;
    trunc_d = !in_valid && state_q == ACTIVE && gap_q == GAP_LAST;
    state_d = (eop_d || trunc_d) ? IDLE : (in_valid ? ACTIVE : state_q);
    cnt_d = (eop_d || trunc_d) ? 12'd0 : (in_valid ? cnt_q + 12'd1 : cnt_q);
    symb_d = trunc_d ? 4'd0 : (eop_d ? (symb_q == SYMB_LAST ? 4'd0 : symb_q + 4'd1) : symb_q);
    gap_d = (in_valid || trunc_d) ? '0 : (state_q == ACTIVE ? gap_q + GAP_ONE : gap_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      symb_q <= '0;
      gap_q <= '0;
      out_valid <= 1'b0;
      out_r <= '0;
      out_i <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_symb <= '0;
      out_slot_end <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      symb_q <= symb_d;
      gap_q <= gap_d;
      out_valid <= in_valid;
      out_sop <= sop_d;
      out_eop <= eop_d;
      out_slot_end <= eop_d && symb_q == SYMB_LAST;
      err_len <= trunc_d;
      if (in_valid) begin
        out_r <= in_r;
        out_i <= in_i;
        out_symb <= symb_q;
      end
    end
  end
`ifdef NR_FRAMER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (trunc_d && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_nr_symbol_framer.sv
// tb_nr_symbol_framer: vector table, scripted slot scenarios and randomized traffic
// checked against a model built from absolute sample position within the slot.
`timescale 1ns/1ps
module tb_nr_symbol_framer;
  localparam int W = 26, IFFT = 2048, NCP1 = 160, NCP2 = 144, NS = 14, GAP = 64;
  localparam int SLOT = 2 * (IFFT + NCP1) + (NS - 2) * (IFFT + NCP2);
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [W-1:0] in_r = '0, in_i = '0;
  logic out_valid, out_sop, out_eop, out_slot_end, err_len;
  logic [W-1:0] out_r, out_i;
  logic [3:0] out_symb;
`ifdef NR_FRAMER_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] e_cnt = '0;
`endif
  int starts[NS+1];
  int k, idle, seq, n_cmp, n_bad, n_sop, n_eop, n_slot, n_err, first_eop, last_eop;
  logic e_valid, e_sop, e_eop, e_slot, e_err;
  logic [3:0] e_symb;
  logic [W-1:0] e_r, e_i;
  typedef struct {
    logic rs;
    logic v;
    logic [W-1:0] r;
    logic ev;
    logic es;
    logic [W-1:0] er;
  } vec_t;
  vec_t vt[$];
  nr_symbol_framer dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_r(in_r),
    .in_i(in_i),
    .out_valid(out_valid),
    .out_r(out_r),
    .out_i(out_i),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_symb(out_symb),
    .out_slot_end(out_slot_end),
`ifdef NR_FRAMER_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .err_len(err_len)
  );
  always #5 clk = ~clk;
  function automatic int sym_len(input int s);
    return IFFT + ((s == 0 || s == NS / 2) ? NCP1 : NCP2);
  endfunction
  function automatic bit is_start(input int p);
    for (int s = 0; s <= NS; s++)
      if (starts[s] == p) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int symb_of(input int p);
    int r = 0;
    for (int s = 1; s < NS; s++)
      if (starts[s] <= p) r = s;
    return r;
  endfunction
  function automatic logic [63:0] outs();
    return {3'b0, out_valid, out_sop, out_eop, out_slot_end, err_len, out_symb, out_r, out_i};
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  // k is the slot position of the next sample; a symbol is open whenever k sits off a symbol boundary.
  task automatic model();
    e_sop = 1'b0;
    e_eop = 1'b0;
    e_slot = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      k = 0;
      idle = 0;
      seq = 0;
      e_valid = 1'b0;
      e_symb = '0;
      e_r = '0;
      e_i = '0;
`ifdef NR_FRAMER_ERR_CNT_EN
      e_cnt = '0;
`endif
    end else begin
      e_valid = in_valid;
      if (in_valid) begin
        e_r = in_r;
        e_i = in_i;
        e_symb = 4'(symb_of(k));
        e_sop = is_start(k);
        e_eop = is_start(k + 1);
        e_slot = k == SLOT - 1;
        k = (k + 1) % SLOT;
        idle = 0;
        seq++;
      end else if (!is_start(k)) begin
        idle++;
        if (idle == GAP) begin
          e_err = 1'b1;
          k = 0;
          idle = 0;
`ifdef NR_FRAMER_ERR_CNT_EN
          if (e_cnt != 16'hFFFF) e_cnt++;
`endif
        end
      end
    end
  endtask
  task automatic cycle(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
    in_valid = v;
    in_r = r;
    in_i = i;
    @(posedge clk);
    model();
    #1;
    check("cycle", outs(), {3'b0, e_valid, e_sop, e_eop, e_slot, e_err, e_symb, e_r, e_i});
`ifdef NR_FRAMER_ERR_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(e_cnt));
`endif
    if (out_valid && out_sop) n_sop++;
    if (out_valid && out_eop) begin
      n_eop++;
      last_eop = seq - 1;
      if (first_eop < 0) first_eop = seq - 1;
    end
    if (out_valid && out_slot_end) n_slot++;
    if (err_len) n_err++;
  endtask
  task automatic ramp();
    cycle(1'b1, W'(seq), W'(-seq));
  endtask
  task automatic burst(input int n, input int every, input int len);
    for (int s = 0; s < n; s++) begin
      if (every > 0 && s > 0 && s % every == 0) repeat (len) cycle(1'b0, '0, '0);
      ramp();
    end
  endtask
  task automatic add(input logic rs, input logic v, input int r, input logic ev, input logic es, input int er);
    vec_t x;
    x.rs = rs;
    x.v = v;
    x.r = W'(r);
    x.ev = ev;
    x.es = es;
    x.er = W'(er);
    vt.push_back(x);
  endtask
  initial begin
    starts[0] = 0;
    for (int s = 0; s < NS; s++) starts[s+1] = starts[s] + sym_len(s);
    add(1, 1, 5, 0, 0, 0);
    add(0, 0, 7, 0, 0, 0);
    add(0, 1, 11, 1, 1, 11);
    add(0, 1, 12, 1, 0, 12);
    add(0, 0, 99, 0, 0, 12);
    add(0, 1, 13, 1, 0, 13);
    add(1, 1, 14, 0, 0, 0);
    add(0, 1, 15, 1, 1, 15);
    add(0, 1, 16, 1, 0, 16);
    foreach (vt[n]) begin
      rst = vt[n].rs;
      in_valid = vt[n].v;
      in_r = vt[n].r;
      in_i = vt[n].r;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", n), {out_valid, out_sop, out_eop, out_symb, out_r, out_i},
            {vt[n].ev, vt[n].es, 1'b0, 4'd0, vt[n].er, vt[n].er});
    end
    rst = 1'b1;
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, '0);
    rst = 1'b0;
    n_sop = 0;
    n_eop = 0;
    n_slot = 0;
    n_err = 0;
    first_eop = -1;
    last_eop = -1;
    burst(SLOT, 0, 0);
    check("slotA_sop", n_sop, 14);
    check("slotA_eop", n_eop, 14);
    check("slotA_slot_end", n_slot, 1);
    check("slotA_first_eop", first_eop, 2207);
    check("slotA_last_eop", last_eop, SLOT - 1);
    ramp();
    check("wrap_sop_symb", {out_sop, out_symb}, {1'b1, 4'd0});
    burst(IFFT + NCP1 - 1, 100, GAP - 1);
    check("gap63_eop", last_eop, SLOT + 2207);
    burst(2 * (IFFT + NCP2), 0, 0);
    burst(IFFT + NCP2, 200, 5);
    check("sym3_eop", last_eop, SLOT + 2208 + 3 * 2192 - 1);
    check("no_err_gaps", n_err, 0);
    burst(3 * (IFFT + NCP2), 0, 0);
    burst(1000, 0, 0);
    repeat (GAP - 1) cycle(1'b0, '0, '0);
    check("no_err_before_limit", n_err, 0);
    cycle(1'b0, '0, '0);
    check("err_pulse", {err_len, out_valid}, 2'b10);
    cycle(1'b0, '0, '0);
    check("err_one_cycle", err_len, 0);
    repeat (5) cycle(1'b0, '0, '0);
    check("err_total", n_err, 1);
    ramp();
    check("after_trunc", {out_valid, out_sop, out_symb}, {1'b1, 1'b1, 4'd0});
`ifdef NR_FRAMER_ERR_CNT_EN
    check("err_cnt_one", 64'(err_cnt), 64'd1);
`endif
    for (int g = 0; g < 40000 && k != starts[5] + 1500; g++)
      cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
    check("in_sym5", out_symb, 5);
    rst = 1'b1;
    #1;
    check("async_rst", outs(), 64'd0);
`ifdef NR_FRAMER_ERR_CNT_EN
    check("async_rst_cnt", 64'(err_cnt), 64'd0);
`endif
    cycle(1'b0, '0, '0);
    cycle(1'b1, W'(5), W'(5));
    rst = 1'b0;
    ramp();
    check("post_rst", {out_sop, out_symb}, {1'b1, 4'd0});
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 2) repeat ($urandom_range(40, 80)) cycle(1'b0, '0, '0);
      else cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
